mem_subword_stage: RTL

MEM_SUBWORD_STAGE -- requirements
Module: mem_subword_stage

---
 rtl/mem_subword_stage_pkg.sv | 27 ++
 rtl/mem_load_align.sv | 28 ++
 rtl/mem_subword_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_subword_stage_pkg.sv
// Shared definitions for the memory sub-word stage: funct3 codes, FSM encoding,
// and the pipeline/cache byte-order conversion.
package mem_subword_stage_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RMW_RD = 2'd1,
    ST_RMW_WR = 2'd2
  } state_e;

  // Pipeline byte k sits at cache bits [31-8k:24-8k]; the mapping is its own inverse.
  function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extraction: selects the addressed byte/halfword of a
// pipeline-order word and sign- or zero-extends it according to funct3.
module mem_load_align
  import mem_subword_stage_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [1:0]        lane,
  input  logic [2:0]        funct3,
  output logic [WORD_W-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{lane, 3'b000} +: 8];
    half_v = rdata[{lane[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data = {{24{byte_v[7]}}, byte_v};
      F3_LH:   data = {{16{half_v[15]}}, half_v};
      F3_LBU:  data = {24'h000000, byte_v};
      F3_LHU:  data = {16'h0000, half_v};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_subword_stage.sv
// Memory pipeline stage with byte/halfword stores done as cache read-modify-write.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHK_EN.
module mem_subword_stage
  import mem_subword_stage_pkg::*;
#(
  parameter int unsigned BIT_W  = 32,
  parameter int unsigned ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIT_W-1:0]  alu_result_in,
  input  logic [BIT_W-1:0]  mem_wdata_in,
  input  logic [2:0]        funct3_in,
  input  logic              memrd_in,
  input  logic              memwr_in,
  input  logic [BIT_W-1:0]  PC_plus_4_in,
  input  logic [4:0]        rd_in,
  input  logic              mem2reg_in,
  input  logic              regwr_in,
  input  logic              jump_in,
  output logic [BIT_W-1:0]  alu_result_out,
  output logic [BIT_W-1:0]  PC_plus_4_out,
  output logic [BIT_W-1:0]  mem_dat,
  output logic [4:0]        rd_out,
  output logic              mem2reg_out,
  output logic              regwr_out,
  output logic              jump_out,
  output logic              stall_out,
  input  logic              DCACHE_stall,
  output logic              DCACHE_ren,
  output logic              DCACHE_wen,
  output logic [ADDR_W-1:0] DCACHE_addr,
  input  logic [BIT_W-1:0]  DCACHE_rdata,
  output logic [BIT_W-1:0]  DCACHE_wdata
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic              misalign_out
`endif
);

  state_e            state, state_nxt;
  logic              is_store, is_load, is_byte, is_half, sub_store, misalign;
  logic              ren, wen, stall, merge_load;
  logic [BIT_W-1:0]  merge_q, merged, rdata_pipe, load_data;

  // Both strobes high means store; funct3 meaning depends on direction.
  assign is_store = memwr_in;
  assign is_load  = memrd_in & ~memwr_in;

  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    if (is_store) begin
      is_byte = (funct3_in == F3_SB);
      is_half = (funct3_in == F3_SH);
    end else if (is_load) begin
      is_byte = (funct3_in == F3_LB) || (funct3_in == F3_LBU);
      is_half = (funct3_in == F3_LH) || (funct3_in == F3_LHU);
    end
  end

  assign sub_store = is_store & (is_byte | is_half);

`ifdef MEM_MISALIGN_CHK_EN
  assign misalign = (is_half & alu_result_in[0])
                  | ((is_load | is_store) & ~is_byte & ~is_half & (alu_result_in[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign rdata_pipe  = bswap32(DCACHE_rdata);
  assign DCACHE_addr = ADDR_W'(alu_result_in[BIT_W-1:2]);

  mem_load_align u_load_align (
    .rdata  (rdata_pipe),
    .lane   (alu_result_in[1:0]),
    .funct3 (funct3_in),
    .data   (load_data)
  );

  // Captured word with the store's byte/halfword patched in (pipeline order).
  always_comb begin
    merged = merge_q;
    if (funct3_in == F3_SB) merged[{alu_result_in[1:0], 3'b000} +: 8] = mem_wdata_in[7:0];
    else                    merged[{alu_result_in[1], 4'b0000} +: 16] = mem_wdata_in[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ren          = 1'b0;
    wen          = 1'b0;
    stall        = 1'b0;
    merge_load   = 1'b0;
    DCACHE_wdata = bswap32(mem_wdata_in);
    case (state)
      ST_IDLE: begin
        if (misalign) begin
          stall = 1'b0;
        end else if (sub_store) begin
          ren       = 1'b1;
          stall     = 1'b1;
          state_nxt = ST_RMW_RD;
        end else if (is_store) begin
          wen   = 1'b1;
          stall = DCACHE_stall;
        end else if (is_load) begin
          ren   = 1'b1;
          stall = DCACHE_stall;
        end
      end
      ST_RMW_RD: begin
        ren   = 1'b1;
        stall = 1'b1;
        if (!DCACHE_stall) begin
          merge_load = 1'b1;
          state_nxt  = ST_RMW_WR;
        end
      end
      ST_RMW_WR: begin
        wen          = 1'b1;
        DCACHE_wdata = bswap32(merged);
        stall        = DCACHE_stall;
        if (!DCACHE_stall) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are suppressed while reset is held.
  assign DCACHE_ren = ren & rst_n;
  assign DCACHE_wen = wen & rst_n;
  assign stall_out  = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          merge_q <= '0;
    else if (merge_load) merge_q <= rdata_pipe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_out <= '0;
      PC_plus_4_out  <= '0;
      mem_dat        <= '0;
      rd_out         <= '0;
      mem2reg_out    <= 1'b0;
      regwr_out      <= 1'b0;
      jump_out       <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
      misalign_out   <= 1'b0;
`endif
    end else if (!stall) begin
      alu_result_out <= alu_result_in;
      PC_plus_4_out  <= PC_plus_4_in;
      mem_dat        <= load_data;
      rd_out         <= rd_in;
      mem2reg_out    <= mem2reg_in;
      regwr_out      <= regwr_in & ~misalign;
      jump_out       <= jump_in;
`ifdef MEM_MISALIGN_CHK_EN
      misalign_out   <= misalign;
`endif
    end
  end

endmodule
